// File: rtl/and_gate.sv
// and_gate: bitwise AND of two operands with a combinational output and a
// PIPE_STAGES-deep valid-qualified registered copy. The registered result
// also drives all-ones, any-one and population-count flags.
// Legal ranges: WIDTH 1..64, PIPE_STAGES 1..4.
module and_gate #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           in_valid,
  output logic [WIDTH-1:0]               y,
  output logic [WIDTH-1:0]               y_q,
  output logic                           out_valid,
  output logic                           all_ones,
  output logic                           any_one,
  output logic [$clog2(WIDTH+1)-1:0]     ones_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Number of set bits; CNT_W is sized so WIDTH itself fits without wrapping.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Combinational path: independent of clk and rst_n.
  assign y = a & b;

  // Each stage carries data plus its valid bit. Stage 0 samples the inputs,
  // later stages copy their predecessor. Data only moves when the incoming
  // valid is set, so an idle pipeline keeps presenting the last result.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] data_in;
    logic             vld_in;
    logic [WIDTH-1:0] data_p;
    logic             vld_p;

    if (s == 0) begin : g_first
      assign data_in = a & b;
      assign vld_in  = in_valid;
    end else begin : g_next
      assign data_in = g_stage[s-1].data_p;
      assign vld_in  = g_stage[s-1].vld_p;
    end

    // Stage register: valid follows every edge, data loads only when valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_p <= '0;
        vld_p  <= 1'b0;
      end else begin
        vld_p <= vld_in;
        if (vld_in) begin
          data_p <= data_in;
        end
      end
    end
  end

  // Last stage drives the registered outputs.
  assign y_q       = g_stage[PIPE_STAGES-1].data_p;
  assign out_valid = g_stage[PIPE_STAGES-1].vld_p;

  // Flags are derived from y_q alone, regardless of out_valid; reset zeroes
  // y_q, which makes all three flags read 0 during reset.
  assign all_ones   = &y_q;
  assign any_one    = |y_q;
  assign ones_count = popcount(y_q);

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: randomized self-checking bench for and_gate. Several instances
// with different WIDTH/PIPE_STAGES share stimulus; a history-based model
// derives expected registered outputs from the sampled input sequence.
module tb_and_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        a1, b1;
  logic [7:0]  a8, b8;
  logic [63:0] a64, b64;

  // WIDTH=1, PIPE_STAGES=1
  logic       y_w1, yq_w1, ov_w1, ao_w1, an_w1;
  logic [0:0] oc_w1;
  // WIDTH=8, PIPE_STAGES=1
  logic [7:0] y_p1, yq_p1;
  logic       ov_p1, ao_p1, an_p1;
  logic [3:0] oc_p1;
  // WIDTH=8, PIPE_STAGES=3
  logic [7:0] y_p3, yq_p3;
  logic       ov_p3, ao_p3, an_p3;
  logic [3:0] oc_p3;
  // WIDTH=64, PIPE_STAGES=2
  logic [63:0] y_w64, yq_w64;
  logic        ov_w64, ao_w64, an_w64;
  logic [6:0]  oc_w64;

  and_gate #(.WIDTH(1), .PIPE_STAGES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
    .y(y_w1), .y_q(yq_w1), .out_valid(ov_w1), .all_ones(ao_w1),
    .any_one(an_w1), .ones_count(oc_w1));

  and_gate #(.WIDTH(8), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
    .y(y_p1), .y_q(yq_p1), .out_valid(ov_p1), .all_ones(ao_p1),
    .any_one(an_p1), .ones_count(oc_p1));

  and_gate #(.WIDTH(8), .PIPE_STAGES(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
    .y(y_p3), .y_q(yq_p3), .out_valid(ov_p3), .all_ones(ao_p3),
    .any_one(an_p3), .ones_count(oc_p3));

  and_gate #(.WIDTH(64), .PIPE_STAGES(2)) u_w64 (
    .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .in_valid(in_valid),
    .y(y_w64), .y_q(yq_w64), .out_valid(ov_w64), .all_ones(ao_w64),
    .any_one(an_w64), .ones_count(oc_w64));

  int n_cmp = 0;
  int n_bad = 0;

  // History of what each clock edge out of reset sampled.
  bit          hist_v[$];
  logic [7:0]  hist_d8[$];
  logic [63:0] hist_d64[$];

  always @(posedge clk) begin
    if (rst_n) begin
      hist_v.push_back(in_valid);
      hist_d8.push_back(a8 & b8);
      hist_d64.push_back(a64 & b64);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // After k sampled edges, the output stage reflects edge k-ps+1: its valid
  // bit, and the data of the most recent valid sample up to that edge.
  function automatic void model(input int ps, input bit wide,
                                output logic ev, output logic [63:0] ed);
    int idx;
    idx = hist_v.size() - ps;
    ev  = 1'b0;
    ed  = '0;
    if (idx >= 0) begin
      ev = hist_v[idx];
      for (int i = 0; i <= idx; i++) begin
        if (hist_v[i]) ed = wide ? hist_d64[i] : {56'd0, hist_d8[i]};
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic ev;
    logic [63:0] ed;
    chk({tag, "_y8"},  {56'd0, y_p1}, {56'd0, a8 & b8});
    chk({tag, "_y64"}, y_w64, a64 & b64);

    model(1, 1'b0, ev, ed);
    chk({tag, "_p1_vld"}, 64'(ov_p1), 64'(ev));
    chk({tag, "_p1_yq"},  {56'd0, yq_p1}, ed);
    chk({tag, "_p1_all"}, 64'(ao_p1), 64'(ed[7:0] == 8'hFF));
    chk({tag, "_p1_any"}, 64'(an_p1), 64'(ed != 0));
    chk({tag, "_p1_cnt"}, 64'(oc_p1), 64'($countones(ed)));

    model(3, 1'b0, ev, ed);
    chk({tag, "_p3_vld"}, 64'(ov_p3), 64'(ev));
    chk({tag, "_p3_yq"},  {56'd0, yq_p3}, ed);
    chk({tag, "_p3_all"}, 64'(ao_p3), 64'(ed[7:0] == 8'hFF));
    chk({tag, "_p3_any"}, 64'(an_p3), 64'(ed != 0));
    chk({tag, "_p3_cnt"}, 64'(oc_p3), 64'($countones(ed)));

    model(2, 1'b1, ev, ed);
    chk({tag, "_w64_vld"}, 64'(ov_w64), 64'(ev));
    chk({tag, "_w64_yq"},  yq_w64, ed);
    chk({tag, "_w64_all"}, 64'(ao_w64), 64'(ed == {64{1'b1}}));
    chk({tag, "_w64_any"}, 64'(an_w64), 64'(ed != 0));
    chk({tag, "_w64_cnt"}, 64'(oc_w64), 64'($countones(ed)));
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    a64 = {$urandom, $urandom};
    b64 = {$urandom, $urandom};
  endtask

  logic [1:0] tt_in [4];
  logic       tt_y  [4];
  int         pulses;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0; a64 = '0; b64 = '0;
    #1 rst_n = 1'b0;
    #1;
    // Reset state, before any clock edge.
    chk("rst_p1_yq", {56'd0, yq_p1}, 64'd0);
    chk("rst_p1_vld", 64'(ov_p1), 64'd0);
    chk("rst_w64_yq", yq_w64, 64'd0);
    chk("rst_w64_flags", {61'd0, ao_w64, an_w64, 1'b0}, 64'd0);
    chk("rst_w64_cnt", 64'(oc_w64), 64'd0);
    chk("rst_w1_yq", 64'(yq_w1), 64'd0);
    // y still follows inputs under reset.
    rand_data();
    #1;
    check_all("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // WIDTH=1 truth table: (a,b) = 00, 10, 01, 11.
    tt_in[0] = 2'b00; tt_in[1] = 2'b10; tt_in[2] = 2'b01; tt_in[3] = 2'b11;
    tt_y[0]  = 1'b0;  tt_y[1]  = 1'b0;  tt_y[2]  = 1'b0;  tt_y[3]  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = tt_in[i][1];
      b1 = tt_in[i][0];
      #5;
      chk($sformatf("tt_%0d", i), 64'(y_w1), 64'(tt_y[i]));
    end

    // Single valid F0 & 3C on the one-stage pipeline.
    @(posedge clk); #1;
    a8 = 8'hF0; b8 = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s2_yq", {56'd0, yq_p1}, 64'h30);
    chk("s2_vld", 64'(ov_p1), 64'd1);
    chk("s2_cnt", 64'(oc_p1), 64'd2);
    chk("s2_any", 64'(an_p1), 64'd1);
    chk("s2_all", 64'(ao_p1), 64'd0);
    check_all("s2");
    tick();
    check_all("s2_hold");
    chk("s5_hold_yq", {56'd0, yq_p1}, 64'h30);
    chk("s5_hold_vld", 64'(ov_p1), 64'd0);

    // All-ones then zero operands.
    a8 = 8'hFF; b8 = 8'hFF; a64 = '1; b64 = '1; in_valid = 1'b1;
    tick();
    chk("s3_all", 64'(ao_p1), 64'd1);
    chk("s3_cnt8", 64'(oc_p1), 64'd8);
    check_all("s3a");
    a8 = 8'h00; a64 = '0;
    tick();
    chk("s3_any0", 64'(an_p1), 64'd0);
    chk("s3_cnt0", 64'(oc_p1), 64'd0);
    check_all("s3b");
    in_valid = 1'b0;
    a64 = '1;
    tick();
    check_all("s3c");
    tick();
    check_all("s3d");

    // Five back-to-back valid inputs through the three-stage pipeline.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      in_valid = 1'b1;
      tick();
      check_all("s4_in");
      if (ov_p3) pulses++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all("s4_out");
      if (ov_p3) pulses++;
    end
    chk("s4_pulses", 64'(pulses), 64'd5);

    // Alternating valid pattern, then fully random traffic.
    for (int i = 0; i < 20; i++) begin
      rand_data();
      in_valid = i[0];
      tick();
      check_all("toggle");
    end
    for (int i = 0; i < 200; i++) begin
      rand_data();
      if ((i % 37) == 0) begin a64 = '1; b64 = '1; end
      in_valid = 1'($urandom);
      tick();
      check_all("rand");
    end

    // Mid-stream asynchronous reset with a full pipeline.
    for (int i = 0; i < 4; i++) begin
      rand_data();
      a8 = a8 | 8'h01; b8 = b8 | 8'h01;
      in_valid = 1'b1;
      tick();
      check_all("s6_fill");
    end
    #3 rst_n = 1'b0;
    #1;
    hist_v.delete(); hist_d8.delete(); hist_d64.delete();
    chk("s6_p3_yq", {56'd0, yq_p3}, 64'd0);
    chk("s6_p3_vld", 64'(ov_p3), 64'd0);
    chk("s6_p1_yq", {56'd0, yq_p1}, 64'd0);
    chk("s6_w64_vld", 64'(ov_w64), 64'd0);
    rand_data();
    #1;
    check_all("s6_in_rst");
    tick();
    check_all("s6_in_rst2");
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("s6_idle");
    end
    for (int i = 0; i < 30; i++) begin
      rand_data();
      in_valid = 1'($urandom);
      tick();
      check_all("s6_after");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/and_gate.md
AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter WIDTH, default 1, is the operand width in bits and SHALL be legal from 1 to 64.
REQ-002 Parameter PIPE_STAGES, default 1, is the registered-path latency in clk cycles and SHALL be legal from 1 to 4.
REQ-003 clk  input  1  single clock; all sequential logic SHALL be clocked on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 in_valid  input  1  qualifies a/b for the registered path.
REQ-008 y  output  WIDTH  combinational bitwise AND of a and b.
REQ-009 y_q  output  WIDTH  registered AND result, delayed by PIPE_STAGES cycles.
REQ-010 out_valid  output  1  qualifies y_q.
REQ-011 all_ones  output  1  high when every bit of y_q is 1.
REQ-012 any_one  output  1  high when at least one bit of y_q is 1.
REQ-013 ones_count  output  clog2(WIDTH+1)  number of set bits in y_q.

Function
REQ-014 y SHALL equal a AND b, bit by bit, with zero latency and no dependence on clk or rst_n.
REQ-015 For WIDTH=1, y SHALL follow the truth table 00->0, 10->0, 01->0, 11->1.
REQ-016 Any X or Z on an input bit SHALL propagate per standard AND semantics: 0 AND X = 0, 1 AND X = X.
REQ-017 On each rising clk edge, stage 1 SHALL capture a AND b together with in_valid.
REQ-018 Each later stage SHALL copy the previous stage's data and valid bit.
REQ-019 y_q and out_valid SHALL be driven by the last stage, giving a latency of exactly PIPE_STAGES cycles.
REQ-020 A stage SHALL load its data only when its incoming valid bit is 1 and SHALL otherwise hold its previous data.
REQ-021 Each stage's valid bit SHALL update on every clock edge.
REQ-022 The pipeline SHALL have no backpressure: back-to-back valid inputs SHALL be accepted every cycle at full throughput.
REQ-023 all_ones, any_one and ones_count SHALL be combinational functions of y_q only.
REQ-024 all_ones, any_one and ones_count SHALL be meaningful regardless of out_valid.
REQ-025 ones_count SHALL range from 0 to WIDTH, with no overflow at WIDTH=64 (7-bit output).
REQ-026 in_valid toggling every cycle SHALL yield out_valid as the same pattern delayed by PIPE_STAGES cycles.

Reset
REQ-027 While rst_n=0, all stage data and valid registers SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 During reset, y_q=0, out_valid=0, all_ones=0, any_one=0 and ones_count=0.
REQ-029 y SHALL remain a function of a and b during reset.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight results.
REQ-031 After rst_n deasserts, the first out_valid=1 SHALL appear PIPE_STAGES cycles after the first edge that samples in_valid=1.
REQ-032 rst_n deassertion SHALL be treated as synchronous to clk; no deassertion synchronizer is included in this block.

Verification
REQ-033 Scenario 1 (WIDTH=1): drive a/b = 00, 10, 01, 11, holding each for 5 ns -> y = 0, 0, 0, 1 after each change.
REQ-034 Scenario 2 (WIDTH=8, PIPE_STAGES=1): a=0xF0, b=0x3C, in_valid=1 for one cycle -> next cycle y_q=0x30, out_valid=1, ones_count=2, any_one=1, all_ones=0.
REQ-035 Scenario 3 (WIDTH=8): a=0xFF, b=0xFF valid -> all_ones=1 and ones_count=8; then a=0x00 valid -> any_one=0 and ones_count=0.
REQ-036 Scenario 4 (PIPE_STAGES=3): valid inputs streamed for 5 consecutive cycles -> 5 consecutive out_valid pulses starting 3 cycles later, with data in order.
REQ-037 Scenario 5: after a valid input with y_q nonzero, drive in_valid=0 -> out_valid drops to 0 and y_q holds its last value.
REQ-038 Scenario 6: assert rst_n=0 between clock edges while the pipeline is full -> y_q=0 and out_valid=0 immediately; y still tracks a AND b.
